dvi_line_fifo: RTL and testbench
================================

# dvi_line_fifo

Parametrised single-clock FIFO that buffers pixel and line words between the framebuffer DMA read path and the DVI pixel pipeline. It succeeds the fixed 32-bit × 1024 framebuffer FIFO. Width and depth are parameters, all DEPTH RAM entries are usable, and it adds an occupancy level, a programmable almost-full flag and a synchronous flush. The read side is a registered two-entry output stage, so data_out_o stays stable while the consumer stalls.

## Interface
- WIDTH, 32: data word width in bits (1..256)
- DEPTH, 1024: RAM entries; power of two, minimum 4
- AFULL_LEVEL, DEPTH-16: afull_o asserts when level_o >= AFULL_LEVEL
- clk_i  in  1  sole clock; all logic on the rising edge
- rst_i  in  1  reset; asynchronous assert, active-low, deasserted synchronously outside the block
- flush_i  in  1  synchronous discard of all contents
- data_in_i  in  WIDTH  write data
- push_i  in  1  write request; qualified by accept_o
- accept_o  out  1  RAM occupancy < DEPTH
- data_out_o  out  WIDTH  head word; valid only while valid_o is high
- valid_o  out  1  head word present
- pop_i  in  1  consume the head word; qualified by valid_o
- level_o  out  $clog2(DEPTH+2)+1  accepted words not yet popped (RAM, in-flight read and output stage)
- afull_o  out  1  level_o >= AFULL_LEVEL, registered
- overflow_o  out  1  sticky: push_i while !accept_o
- underflow_o  out  1  sticky: pop_i while !valid_o

## Operation
- Pointers are $clog2(DEPTH)+1 bits wide; the extra MSB tells full from empty.
  - RAM occupancy = wr_ptr - rd_ptr, modulo 2^(ptr width).
  - Full means occupancy == DEPTH; empty means the pointers are equal.
- Write: push_i && accept_o && !flush_i writes RAM[wr_ptr] and increments wr_ptr. A push while full is dropped and does not alter the RAM.
- Prefetch: a read issues when RAM is non-empty and (output-stage count + in-flight count - pop this cycle) < 2. The RAM read is synchronous: data lands in the output stage one cycle after issue.
- Output stage: a two-entry register FIFO. The head drives data_out_o and valid_o.
  - Pop with valid_o high advances the head.
  - Pop with valid_o low is ignored.
- Pointer wrap: both pointers wrap naturally at 2^(ptr width). No special case is allowed at the DEPTH-1 → 0 transition.
- level_o:
  - +1 on an accepted push, -1 on an accepted pop, unchanged when both occur.
  - Maximum value is DEPTH+2.
- Flush (flush_i high in cycle N):
  - From the N+1 edge: pointers are zero, the output stage and in-flight read are cleared, and level_o = 0.
  - Push and pop in cycle N are ignored.
  - Sticky flags are cleared.
- Reset values: accept_o=1, valid_o=0, data_out_o=0, level_o=0, afull_o=0 (1 if AFULL_LEVEL==0), overflow_o=0, underflow_o=0.
- Reset mid-operation: all state clears asynchronously, and RAM contents become don't-care.

## Timing
- Write-to-read latency: a push into an empty FIFO accepted in cycle N gives valid_o=1 in cycle N+2, carrying that data.
- Back-to-back throughput: one push and one pop per cycle, sustained indefinitely, with no bubbles once valid_o is high.
- Stability: while valid_o && !pop_i, data_out_o and valid_o hold their values.
- accept_o and the full condition update on the edge that completes the write. A read freeing a RAM slot in cycle N raises accept_o in cycle N+1.
- Status latency: afull_o and level_o are registered and track the edge of the causing event, with no extra lag.

## Configuration
- DVI_LINE_FIFO_ERR_EN defined: overflow_o and underflow_o are sticky error flags, cleared only by reset or flush_i.
- Not defined: overflow_o and underflow_o are tied to 0 and no error logic is synthesised.

## Structure
- Shared package dvi_video_pkg holds:
  - the pointer-width function clog2_f
  - the default width and depth constants DVI_FIFO_WIDTH=32 and DVI_FIFO_DEPTH=1024
- Sub-module dvi_line_fifo_ram: a parametrised simple dual-port RAM with one write port, one synchronous read port and no reset on the array, inferrable as block RAM.

## Test plan
- Reset, then 4 pushes (0x11,0x22,0x33,0x44) with pop_i=0 → valid_o high 2 cycles after the first push, data_out_o=0x11 held stable; level_o=4.
- DEPTH=8: 12 pushes with no pops → accept_o=0 once level_o=10 (8 RAM + 2 stage); the extra pushes are dropped and overflow_o=1 with ERR_EN defined. Drain 10 words → they arrive in order 0..9.
- Simultaneous push and pop every cycle for 3×DEPTH words, with the pointers crossing the wrap 3 times → output is in order with no gaps, and level_o stays constant.
- Random pop_i stalls (50%) against continuous pushes → data_out_o never changes while valid_o && !pop_i, and no word is lost or duplicated.
- flush_i pulsed with level_o=5, a push and a pop in the same cycle → next cycle: level_o=0, valid_o=0, accept_o=1, and the flush-cycle push is absent.
- AFULL_LEVEL=6, DEPTH=8 → afull_o rises on the edge where level_o becomes 6 and falls on the edge where it becomes 5.

Source files
------------

// File: rtl/dvi_video_pkg.sv
// Shared constants and helpers for the DVI video datapath blocks.
package dvi_video_pkg;

  localparam int DVI_FIFO_WIDTH = 32;
  localparam int DVI_FIFO_DEPTH = 1024;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2_f(input int value);
    int unsigned v;
    int          result;
    v      = (value > 1) ? unsigned'(value - 1) : 0;
    result = 0;
    while (v != 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dvi_line_fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port, no reset
// on the array so it maps onto block RAM.
module dvi_line_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Synchronous read port; output register holds between reads.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/dvi_line_fifo.sv
// Single-clock FIFO between framebuffer DMA read and the DVI pixel pipeline.
// RAM body with a prefetching two-entry output stage, occupancy level,
// registered almost-full flag and synchronous flush.
// Optional: define DVI_LINE_FIFO_ERR_EN for sticky overflow/underflow flags.
module dvi_line_fifo
  import dvi_video_pkg::*;
#(
  parameter  int WIDTH       = DVI_FIFO_WIDTH,
  parameter  int DEPTH       = DVI_FIFO_DEPTH,
  parameter  int AFULL_LEVEL = DEPTH - 16,
  localparam int PW          = clog2_f(DEPTH) + 1,
  localparam int LW          = $clog2(DEPTH + 2) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             push_i,
  output logic             accept_o,
  output logic [WIDTH-1:0] data_out_o,
  output logic             valid_o,
  input  logic             pop_i,
  output logic [LW-1:0]    level_o,
  output logic             afull_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam bit AFULL_RST = (AFULL_LEVEL <= 0);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    occupancy;
  logic             full;
  logic             empty;
  logic             valid;
  logic             push_ok;
  logic             pop_ok;
  logic             issue;
  logic             keep;
  logic [1:0]       stage_cnt;
  logic [1:0]       after_pop;
  logic             inflight;
  logic [WIDTH-1:0] stage0;
  logic [WIDTH-1:0] stage1;
  logic [WIDTH-1:0] rd_data;
  logic [LW-1:0]    level;
  logic [LW-1:0]    level_next;
  logic             afull;

  // Handshake, prefetch and output-stage bookkeeping.
  always_comb begin
    occupancy  = wr_ptr - rd_ptr;
    full       = (occupancy == PW'(DEPTH));
    empty      = (occupancy == '0);
    valid      = (stage_cnt != 2'd0) || inflight;
    push_ok    = push_i && !full && !flush_i;
    pop_ok     = pop_i && valid && !flush_i;
    issue      = !empty && !flush_i &&
                 (({1'b0, stage_cnt} + 3'(inflight) - 3'(pop_ok)) < 3'd2);
    after_pop  = stage_cnt - 2'(pop_ok && (stage_cnt != 2'd0));
    // The in-flight word is the head when the stage is empty; a pop then
    // consumes it directly and it is never captured.
    keep       = inflight && !(pop_ok && (stage_cnt == 2'd0));
    level_next = level + LW'(push_ok) - LW'(pop_ok);
  end

  // Pointers, occupancy level and almost-full flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      afull  <= AFULL_RST;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      afull  <= AFULL_RST;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_ok);
      rd_ptr <= rd_ptr + PW'(issue);
      level  <= level_next;
      afull  <= (int'(level_next) >= AFULL_LEVEL);
    end
  end

  // Two-entry output stage fed by the synchronous RAM read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stage_cnt <= '0;
      inflight  <= 1'b0;
      stage0    <= '0;
      stage1    <= '0;
    end else if (flush_i) begin
      stage_cnt <= '0;
      inflight  <= 1'b0;
      stage0    <= '0;
      stage1    <= '0;
    end else begin
      inflight  <= issue;
      stage_cnt <= after_pop + 2'(keep);
      if (pop_ok && (stage_cnt == 2'd2)) stage0 <= stage1;
      if (keep) begin
        if (after_pop == 2'd0) stage0 <= rd_data;
        else                   stage1 <= rd_data;
      end
    end
  end

  dvi_line_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW - 1)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (push_ok),
    .wr_addr_i (wr_ptr[PW-2:0]),
    .wr_data_i (data_in_i),
    .rd_en_i   (issue),
    .rd_addr_i (rd_ptr[PW-2:0]),
    .rd_data_o (rd_data)
  );

  // Head bypasses from the RAM output register while the stage is empty,
  // which gives the two-cycle write-to-read latency.
  assign data_out_o = ((stage_cnt == 2'd0) && inflight) ? rd_data : stage0;
  assign valid_o    = valid;
  assign accept_o   = !full;
  assign level_o    = level;
  assign afull_o    = afull;

`ifdef DVI_LINE_FIFO_ERR_EN
  logic overflow;
  logic underflow;

  // Sticky error flags, cleared by reset or flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_i && full)  overflow  <= 1'b1;
      if (pop_i && !valid) underflow <= 1'b1;
    end
  end

  assign overflow_o  = overflow;
  assign underflow_o = underflow;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_dvi_line_fifo.sv
// Self-checking bench for dvi_line_fifo (WIDTH=16, DEPTH=8, AFULL_LEVEL=6).
module tb_dvi_line_fifo;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int LW = $clog2(D + 2) + 1;

  localparam bit ERR =
`ifdef DVI_LINE_FIFO_ERR_EN
    1'b1;
`else
    1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [W-1:0]  data_in_i = '0;
  logic          push_i = 1'b0;
  logic          accept_o;
  logic [W-1:0]  data_out_o;
  logic          valid_o;
  logic          pop_i = 1'b0;
  logic [LW-1:0] level_o;
  logic          afull_o;
  logic          overflow_o;
  logic          underflow_o;

  int errors = 0;
  int checks = 0;

  dvi_line_fifo #(
    .WIDTH       (W),
    .DEPTH       (D),
    .AFULL_LEVEL (AF)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .data_in_i   (data_in_i),
    .push_i      (push_i),
    .accept_o    (accept_o),
    .data_out_o  (data_out_o),
    .valid_o     (valid_o),
    .pop_i       (pop_i),
    .level_o     (level_o),
    .afull_o     (afull_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  typedef struct {
    bit          flush;
    bit          push;
    bit          pop;
    logic [15:0] din;
    bit          e_valid;
    logic [15:0] e_dout;
    int          e_level;
    bit          e_accept;
    bit          e_afull;
    bit          e_unf;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(bit f, bit pu, bit po, logic [15:0] din,
                              bit v, logic [15:0] d, int l, bit a, bit af, bit u);
    vec_t r;
    r.flush = f;  r.push = pu; r.pop = po; r.din = din;
    r.e_valid = v; r.e_dout = d; r.e_level = l;
    r.e_accept = a; r.e_afull = af; r.e_unf = u;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] q[$];
  logic [15:0] nd;
  logic [15:0] prev_dout;
  logic [15:0] exp_word;
  bit          prev_hold;

  initial begin
    // Basic push / hold / pop / underflow / flush sequence.
    tbl[0]  = mk(0, 1, 0, 16'h0011, 0, 16'h0000, 1, 1, 0, 0);
    tbl[1]  = mk(0, 1, 0, 16'h0022, 1, 16'h0011, 2, 1, 0, 0);
    tbl[2]  = mk(0, 1, 0, 16'h0033, 1, 16'h0011, 3, 1, 0, 0);
    tbl[3]  = mk(0, 1, 0, 16'h0044, 1, 16'h0011, 4, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 16'h0000, 1, 16'h0011, 4, 1, 0, 0);
    tbl[5]  = mk(0, 0, 1, 16'h0000, 1, 16'h0022, 3, 1, 0, 0);
    tbl[6]  = mk(0, 0, 1, 16'h0000, 1, 16'h0033, 2, 1, 0, 0);
    tbl[7]  = mk(0, 0, 1, 16'h0000, 1, 16'h0044, 1, 1, 0, 0);
    tbl[8]  = mk(0, 0, 1, 16'h0000, 0, 16'h0000, 0, 1, 0, 0);
    tbl[9]  = mk(0, 0, 1, 16'h0000, 0, 16'h0000, 0, 1, 0, ERR);
    tbl[10] = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 0);

    // Reset.
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_dout", 32'(data_out_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_accept", 32'(accept_o), 32'd1);
    chk("rst_afull", 32'(afull_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_unf", 32'(underflow_o), 32'd0);

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      flush_i = tbl[i].flush; push_i = tbl[i].push;
      pop_i = tbl[i].pop; data_in_i = tbl[i].din;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(valid_o), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid)
        chk($sformatf("tbl%0d_dout", i), 32'(data_out_o), 32'(tbl[i].e_dout));
      chk($sformatf("tbl%0d_level", i), 32'(level_o), 32'(tbl[i].e_level));
      chk($sformatf("tbl%0d_accept", i), 32'(accept_o), 32'(tbl[i].e_accept));
      chk($sformatf("tbl%0d_afull", i), 32'(afull_o), 32'(tbl[i].e_afull));
      chk($sformatf("tbl%0d_unf", i), 32'(underflow_o), 32'(tbl[i].e_unf));
    end
    flush_i = 0; push_i = 0; pop_i = 0;

    // Fill past capacity: 12 pushes, 10 fit (8 RAM + 2 stage).
    for (int i = 0; i < 12; i++) begin
      int el;
      push_i = 1; data_in_i = 16'(i);
      step();
      el = (i + 1 < 10) ? i + 1 : 10;
      chk($sformatf("fill%0d_level", i), 32'(level_o), 32'(el));
      chk($sformatf("fill%0d_accept", i), 32'(accept_o), 32'(el < 10));
      chk($sformatf("fill%0d_afull", i), 32'(afull_o), 32'(el >= AF));
    end
    push_i = 0;
    chk("fill_ovf", 32'(overflow_o), 32'(ERR));

    // Drain in order, afull falls when level reaches 5.
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("drain%0d_valid", j), 32'(valid_o), 32'd1);
      chk($sformatf("drain%0d_dout", j), 32'(data_out_o), 32'(j));
      pop_i = 1;
      step();
      chk($sformatf("drain%0d_level", j), 32'(level_o), 32'(9 - j));
      chk($sformatf("drain%0d_afull", j), 32'(afull_o), 32'((9 - j) >= AF));
    end
    pop_i = 0;
    chk("drain_empty_valid", 32'(valid_o), 32'd0);

    // Streaming push+pop across pointer wrap (pointers start at 10).
    for (int c = 0; c < 26; c++) begin
      push_i = (c < 24); data_in_i = 16'hA000 + 16'(c); pop_i = (c >= 2);
      chk($sformatf("wrap%0d_valid", c), 32'(valid_o), 32'(c >= 2));
      if (c >= 2)
        chk($sformatf("wrap%0d_dout", c), 32'(data_out_o), 32'(16'hA000 + 16'(c - 2)));
      step();
      if (c >= 1 && c <= 23)
        chk($sformatf("wrap%0d_level", c), 32'(level_o), 32'd2);
    end
    push_i = 0; pop_i = 0;
    chk("wrap_end_valid", 32'(valid_o), 32'd0);
    chk("wrap_end_level", 32'(level_o), 32'd0);

    // Random pop stalls against continuous pushes, scoreboard check.
    nd = 16'h3000;
    prev_hold = 0;
    prev_dout = '0;
    for (int c = 0; c < 150; c++) begin
      push_i = 1; data_in_i = nd; pop_i = 1'($urandom_range(0, 1));
      if (prev_hold) begin
        chk("stall_valid", 32'(valid_o), 32'd1);
        chk("stall_dout", 32'(data_out_o), 32'(prev_dout));
      end
      if (pop_i && valid_o) begin
        if (q.size() == 0) chk("rand_underrun", 32'd1, 32'd0);
        else begin
          exp_word = q.pop_front();
          chk("rand_dout", 32'(data_out_o), 32'(exp_word));
        end
      end
      if (accept_o) begin
        q.push_back(nd);
        nd++;
      end
      prev_hold = valid_o && !pop_i;
      prev_dout = data_out_o;
      step();
    end
    push_i = 0;
    for (int c = 0; c < 30 && q.size() > 0; c++) begin
      pop_i = 1;
      if (valid_o) begin
        exp_word = q.pop_front();
        chk("rdrain_dout", 32'(data_out_o), 32'(exp_word));
      end
      step();
    end
    pop_i = 0;
    chk("rdrain_left", 32'(q.size()), 32'd0);
    chk("rdrain_valid", 32'(valid_o), 32'd0);
    chk("rdrain_level", 32'(level_o), 32'd0);

    // Flush with level 5 plus a push and pop in the flush cycle.
    pop_i = 1;
    step();
    pop_i = 0;
    chk("pre_flush_unf", 32'(underflow_o), 32'(ERR));
    chk("pre_flush_ovf", 32'(overflow_o), 32'(ERR));
    for (int i = 0; i < 5; i++) begin
      push_i = 1; data_in_i = 16'h0051 + 16'(i);
      step();
    end
    push_i = 0;
    chk("pre_flush_level", 32'(level_o), 32'd5);
    chk("pre_flush_head", 32'(data_out_o), 32'h51);
    flush_i = 1; push_i = 1; data_in_i = 16'hBEEF; pop_i = 1;
    step();
    flush_i = 0; push_i = 0; pop_i = 0;
    chk("flush_level", 32'(level_o), 32'd0);
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_accept", 32'(accept_o), 32'd1);
    chk("flush_afull", 32'(afull_o), 32'd0);
    chk("flush_ovf", 32'(overflow_o), 32'd0);
    chk("flush_unf", 32'(underflow_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_flush_valid", 32'(valid_o), 32'd0);
      chk("post_flush_level", 32'(level_o), 32'd0);
    end
    push_i = 1; data_in_i = 16'h0077;
    step();
    push_i = 0;
    chk("lat_n1_valid", 32'(valid_o), 32'd0);
    step();
    chk("lat_n2_valid", 32'(valid_o), 32'd1);
    chk("lat_n2_dout", 32'(data_out_o), 32'h77);
    chk("lat_n2_level", 32'(level_o), 32'd1);
    pop_i = 1;
    step();
    pop_i = 0;
    chk("lat_pop_valid", 32'(valid_o), 32'd0);
    chk("lat_pop_level", 32'(level_o), 32'd0);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 3; i++) begin
      push_i = 1; data_in_i = 16'h0061 + 16'(i);
      step();
    end
    push_i = 0;
    chk("pre_rst_level", 32'(level_o), 32'd3);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_level", 32'(level_o), 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_dout", 32'(data_out_o), 32'd0);
    chk("arst_accept", 32'(accept_o), 32'd1);
    chk("arst_afull", 32'(afull_o), 32'd0);
    step();
    rst_i = 1'b1;
    step();
    chk("post_rst_valid", 32'(valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
